// File: rtl/mul_reservation_station.sv
// Reservation station feeding the multiply unit: holds instructions until op1/op2/XER are ready.
// Optional macro MUL_RS_WAKEUP_BYPASS_EN lets CDB wakeups issue in the broadcast cycle.
package mul_rs_pkg;
  typedef struct packed {
    logic high;
    logic signedOp;
    logic word;
    logic oe;
    logic rc;
  } mul_decode_t;
endpackage

module mul_reservation_station
  import mul_rs_pkg::*;
#(
  parameter int RS_ID_WIDTH = 5,
  parameter int RS_OFFSET   = 0,
  parameter int RS_DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dispatch_valid,
  output logic                   dispatch_ready,
  input  logic [4:0]             dispatch_result_reg_addr,
  input  mul_decode_t            dispatch_control,
  input  logic                   op1_valid,
  input  logic                   op2_valid,
  input  logic                   xer_valid,
  input  logic [31:0]            op1_value,
  input  logic [31:0]            op2_value,
  input  logic [31:0]            xer_value,
  input  logic [RS_ID_WIDTH-1:0] op1_tag,
  input  logic [RS_ID_WIDTH-1:0] op2_tag,
  input  logic [RS_ID_WIDTH-1:0] xer_tag,
  input  logic                   cdb_valid,
  input  logic [RS_ID_WIDTH-1:0] cdb_rs_id,
  input  logic [31:0]            cdb_result,
  input  logic                   cdb_xer_valid,
  input  logic [31:0]            cdb_xer,
  output logic                   output_valid,
  input  logic                   output_ready,
  output logic [RS_ID_WIDTH-1:0] rs_id_out,
  output logic [4:0]             result_reg_addr_out,
  output logic [31:0]            op1,
  output logic [31:0]            op2,
  output logic [31:0]            xer,
  output mul_decode_t            control
);

  localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

  // Operand index 0 = op1, 1 = op2, 2 = xer throughout.
  logic [RS_DEPTH-1:0]              busy_q, busy_d;
  logic [2:0]                       rdy_q [RS_DEPTH];
  logic [2:0]                       rdy_d [RS_DEPTH];
  logic [2:0][31:0]                 val_q [RS_DEPTH];
  logic [2:0][31:0]                 val_d [RS_DEPTH];
  logic [2:0][RS_ID_WIDTH-1:0]      tag_q [RS_DEPTH];
  logic [2:0][RS_ID_WIDTH-1:0]      tag_d [RS_DEPTH];
  logic [4:0]                       rd_q [RS_DEPTH];
  logic [4:0]                       rd_d [RS_DEPTH];
  mul_decode_t                      ctrl_q [RS_DEPTH];
  mul_decode_t                      ctrl_d [RS_DEPTH];
  logic                             hold_q, hold_d;
  logic [IDX_W-1:0]                 holdIdx_q, holdIdx_d;

  logic [2:0][31:0]                 cdbVal;
  logic [2:0]                       cdbOk;
  logic [2:0]                       dispValid;
  logic [2:0][31:0]                 dispVal;
  logic [2:0][RS_ID_WIDTH-1:0]      dispTag;
  logic [2:0]                       wake [RS_DEPTH];
  logic [RS_DEPTH-1:0]              canIssue;
  logic                             freeFound, selFound, issueValid, dispFire;
  logic [IDX_W-1:0]                 freeIdx, selIdx;
  logic [2:0][31:0]                 selOps;

  assign cdbVal    = {cdb_xer, cdb_result, cdb_result};
  assign cdbOk     = {cdb_valid & cdb_xer_valid, cdb_valid, cdb_valid};
  assign dispValid = {xer_valid, op2_valid, op1_valid};
  assign dispVal   = {xer_value, op2_value, op1_value};
  assign dispTag   = {xer_tag, op2_tag, op1_tag};

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      wake[i] = '0;
      for (int k = 0; k < 3; k++) begin
        wake[i][k] = busy_q[i] & ~rdy_q[i][k] & cdbOk[k] & (tag_q[i][k] == cdb_rs_id);
      end
`ifdef MUL_RS_WAKEUP_BYPASS_EN
      canIssue[i] = busy_q[i] & (&(rdy_q[i] | wake[i]));
`else
      canIssue[i] = busy_q[i] & (&rdy_q[i]);
`endif
    end
  end

  // A stalled selection stays locked so the multiply unit sees stable fields.
  always_comb begin
    freeFound = 1'b0;
    freeIdx   = '0;
    selFound  = hold_q;
    selIdx    = holdIdx_q;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (!busy_q[i] && !freeFound) begin
        freeFound = 1'b1;
        freeIdx   = IDX_W'(i);
      end
      if (canIssue[i] && !selFound) begin
        selFound = 1'b1;
        selIdx   = IDX_W'(i);
      end
    end
  end

  assign dispatch_ready = freeFound;
  assign dispFire       = dispatch_valid & freeFound;
  assign issueValid     = selFound & ~rst;

  always_comb begin
    for (int k = 0; k < 3; k++) begin
`ifdef MUL_RS_WAKEUP_BYPASS_EN
      selOps[k] = wake[selIdx][k] ? cdbVal[k] : val_q[selIdx][k];
`else
      selOps[k] = val_q[selIdx][k];
`endif
    end
  end

  always_comb begin
    output_valid        = issueValid;
    rs_id_out           = RS_ID_WIDTH'(RS_OFFSET);
    result_reg_addr_out = '0;
    control             = '0;
    op1                 = '0;
    op2                 = '0;
    xer                 = '0;
    if (issueValid) begin
      rs_id_out           = RS_ID_WIDTH'(RS_OFFSET) + RS_ID_WIDTH'(selIdx);
      result_reg_addr_out = rd_q[selIdx];
      control             = ctrl_q[selIdx];
      op1                 = selOps[0];
      op2                 = selOps[1];
      xer                 = selOps[2];
    end
  end

  // Wakeup, issue and dispatch touch disjoint slots, so their order here is free.
  always_comb begin
    busy_d    = busy_q;
    rdy_d     = rdy_q;
    val_d     = val_q;
    tag_d     = tag_q;
    rd_d      = rd_q;
    ctrl_d    = ctrl_q;
    hold_d    = issueValid & ~output_ready;
    holdIdx_d = selIdx;
    for (int i = 0; i < RS_DEPTH; i++) begin
      for (int k = 0; k < 3; k++) begin
        if (wake[i][k]) begin
          rdy_d[i][k] = 1'b1;
          val_d[i][k] = cdbVal[k];
        end
      end
    end
    if (issueValid && output_ready) begin
      busy_d[selIdx] = 1'b0;
    end
    if (dispFire) begin
      busy_d[freeIdx] = 1'b1;
      rd_d[freeIdx]   = dispatch_result_reg_addr;
      ctrl_d[freeIdx] = dispatch_control;
      for (int k = 0; k < 3; k++) begin
        tag_d[freeIdx][k] = dispTag[k];
        if (dispValid[k]) begin
          rdy_d[freeIdx][k] = 1'b1;
          val_d[freeIdx][k] = dispVal[k];
        end else if (cdbOk[k] && (dispTag[k] == cdb_rs_id)) begin
          rdy_d[freeIdx][k] = 1'b1;
          val_d[freeIdx][k] = cdbVal[k];
        end else begin
          rdy_d[freeIdx][k] = 1'b0;
          val_d[freeIdx][k] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= '0;
      hold_q    <= 1'b0;
      holdIdx_q <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        rdy_q[i] <= '0;
      end
    end else begin
      busy_q    <= busy_d;
      hold_q    <= hold_d;
      holdIdx_q <= holdIdx_d;
      rdy_q     <= rdy_d;
    end
  end

  // Payload is only meaningful while busy, so it needs no reset.
  always_ff @(posedge clk) begin
    val_q  <= val_d;
    tag_q  <= tag_d;
    rd_q   <= rd_d;
    ctrl_q <= ctrl_d;
  end

endmodule

// File: doc/mul_reservation_station.md
# mul_reservation_station

Reservation station that sits directly upstream of the multiply execution unit. Holds dispatched multiply instructions until op1, op2 and XER are all available, snooping the common data bus (CDB) for missing operands. Issues one ready entry per cycle over a valid/ready handshake whose output fields match the multiply unit's input ports one-to-one.

## Interface
- RS_ID_WIDTH, 5: width of all rs_id tags.
- RS_OFFSET, 0: global rs_id of slot 0; slot i has rs_id RS_OFFSET+i.
- RS_DEPTH, 4: number of slots, 1..8.

Ports:
- clk  in  1  clock; single clock domain, rising edge.
- rst  in  1  synchronous, active-high reset.
- dispatch_valid  in  1  dispatch request.
- dispatch_ready  out  1  at least one slot free.
- dispatch_result_reg_addr  in  5  destination GPR.
- dispatch_control  in  mul_decode_t  decoded multiply control.
- op1_valid / op2_valid / xer_valid  in  1 each  operand value present at dispatch.
- op1_value / op2_value / xer_value  in  32 each  operand values.
- op1_tag / op2_tag / xer_tag  in  RS_ID_WIDTH each  producer rs_id when not valid.
- cdb_valid  in  1  CDB broadcast.
- cdb_rs_id  in  RS_ID_WIDTH  producer of broadcast.
- cdb_result  in  32  GPR result.
- cdb_xer_valid  in  1  broadcast carries XER.
- cdb_xer  in  32  XER value.
- output_valid  out  1  an entry is issuable.
- output_ready  in  1  multiply unit accepts.
- rs_id_out  out  RS_ID_WIDTH  global id of issued slot.
- result_reg_addr_out  out  5.
- op1 / op2 / xer  out  32 each.
- control  out  mul_decode_t.

## Operation
- Per slot: busy, result_reg_addr, control, and for each of op1/op2/xer: ready bit, 32-bit value, tag.
- Dispatch fires on dispatch_valid & dispatch_ready; writes lowest-index free slot.
- dispatch_ready = any slot not busy at start of cycle; a slot freed by issue this cycle is not reusable until next cycle.
- Wakeup: when cdb_valid, every busy, not-ready op1/op2 whose tag == cdb_rs_id captures cdb_result; not-ready xer captures cdb_xer only if cdb_xer_valid too.
- Dispatch-time capture: an operand dispatched not-valid whose tag matches the same-cycle CDB broadcast is stored ready with the CDB value. Never lost.
- Issuable slot: busy and all three operands ready. Select lowest index.
- Output fields are driven combinationally from the selected slot; hold stable while output_valid & ~output_ready.
- Issue fires on output_valid & output_ready; slot busy cleared at that edge.
- Dispatch and issue in the same cycle are independent. CDB tag matching a non-busy slot is ignored.
- Full: dispatch_ready=0, dispatch_valid ignored. Empty: output_valid=0.

## Timing
- Reset: all busy/ready bits 0; dispatch_ready=1, output_valid=0, rs_id_out=RS_OFFSET, all other outputs 0.
- rst mid-operation discards all entries in one cycle; no issue in the reset cycle.
- Dispatch with all operands valid -> output_valid earliest next cycle.
- Last operand via CDB at cycle N -> issuable at N+1 (see Configuration).
- Throughput: one dispatch and one issue per cycle.

## Configuration
- MUL_RS_WAKEUP_BYPASS_EN defined: a busy slot whose last missing operands arrive on the CDB in cycle N is issuable in cycle N, with the CDB values forwarded onto op1/op2/xer; priority still lowest index. Dispatch-time capture unaffected (a newly dispatched slot is never issuable in its dispatch cycle).
- Undefined: wakeup becomes visible only after the capture edge (N+1). Default undefined.

## Test plan
- After rst, dispatch op1=0x00000003, op2=0x00000005, xer=0, all valid, reg 7 -> next cycle output_valid=1, rs_id_out=RS_OFFSET, op1=3, op2=5, result_reg_addr_out=7.
- Dispatch op1 tag 0x12 not valid; cdb_valid, cdb_rs_id=0x12, cdb_result=0xDEADBEEF two cycles later -> op1=0xDEADBEEF, output_valid one cycle after broadcast (same cycle with MUL_RS_WAKEUP_BYPASS_EN).
- Dispatch op2 tag 0x09 in the same cycle as CDB rs_id 0x09 value 0x10 -> slot stores op2=0x10, issues next cycle.
- Fill RS_DEPTH=4 with output_ready=0 -> dispatch_ready=0 after 4th dispatch; fifth request not accepted; output fields stable; raise output_ready one cycle -> slot 0 issues, dispatch_ready=1 next cycle.
- Slots 1 and 3 ready, slot 0 waiting -> rs_id_out=RS_OFFSET+1 first, then RS_OFFSET+3.
- rst asserted with 3 busy slots -> next cycle output_valid=0, dispatch_ready=1; later CDB with old tags causes no issue.
